lsu_ctrl: RTL and testbench

- Load/store initiator between the core's execute stage and the data port of the unified memory block.
- Converts RISC-V load/store requests (funct3, byte address, store data) into dm_rd_ctrl / dm_wr_ctrl / dm_addr / dm_din beats.
- Returns sign/zero-extended load data and an error flag over valid/ready handshakes.
- Naturally aligned accesses take one beat. Misaligned accesses are split into byte beats, because the memory cannot access across a word boundary.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_ctrl_load_ext.sv | 25 ++
 rtl/lsu_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 encodings,
// data-memory control codes, FSM state type and a size-decode helper.
package lsu_pkg;

  // RISC-V load/store funct3 encodings (stores use B/H/W only)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Data-memory read controls
  localparam logic [2:0] DM_RD_NONE = 3'b000;
  localparam logic [2:0] DM_RD_LB   = 3'b001;
  localparam logic [2:0] DM_RD_LBU  = 3'b010;
  localparam logic [2:0] DM_RD_LH   = 3'b011;
  localparam logic [2:0] DM_RD_LHU  = 3'b100;
  localparam logic [2:0] DM_RD_LW   = 3'b101;

  // Data-memory write controls
  localparam logic [1:0] DM_WR_NONE = 2'b00;
  localparam logic [1:0] DM_WR_B    = 2'b01;
  localparam logic [1:0] DM_WR_H    = 2'b10;
  localparam logic [1:0] DM_WR_W    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } lsu_state_e;

  // Access size in bytes from funct3[1:0]; illegal encodings are caught
  // separately, so 2'b11 simply maps to 4 here.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_load_ext.sv
// Combinational load-data extension.
//   funct3 : RISC-V load funct3 (LB/LH/LW/LBU/LHU)
//   word   : assembled little-endian data, least-significant byte first
//   data   : sign- or zero-extended result (0 for non-load encodings)
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] data
);

  always_comb begin
    data = '0;
    case (funct3)
      F3_B:    data = {{24{word[7]}}, word[7:0]};
      F3_H:    data = {{16{word[15]}}, word[15:0]};
      F3_W:    data = word;
      F3_BU:   data = {24'h0, word[7:0]};
      F3_HU:   data = {16'h0, word[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator between the execute stage and the data-memory port.
//   req_*   : request handshake (store flag, funct3, byte address, store data)
//   resp_*  : response handshake (extended load data, error flag)
//   dm_*    : data-memory beat controls; dm_dout is combinational read data
// Aligned accesses take one beat; misaligned accesses are split into byte
// beats (or rejected when SPLIT_MISALIGNED = 0).
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITS    = 14,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [2:0]  dm_rd_ctrl,
  output logic [1:0]  dm_wr_ctrl,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout
);

  lsu_state_e  state_q, state_d;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  beats_q;
  logic [1:0]  k_q;
  logic        split_q;
  logic [31:0] asm_q;
  logic [31:0] rdata_q;
  logic        err_q;

  // Request classification
  logic [2:0]  req_size;
  logic        req_illegal;
  logic        req_oor;
  logic        req_misal;
  logic        req_fault;
  logic [32:0] req_end;

  always_comb begin
    req_size    = size_of(req_funct3);
    req_illegal = req_we ? (req_funct3 > F3_W)
                         : (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                            req_funct3 == 3'b111);
    req_end     = {1'b0, req_addr} + 33'(req_size) - 33'd1;
    req_oor     = (req_end >= (33'd1 << MEM_ADDR_BITS));
    req_misal   = (req_size == 3'd2 && req_addr[0]) ||
                  (req_size == 3'd4 && req_addr[1:0] != 2'b00);
    req_fault   = req_illegal || req_oor || (req_misal && !SPLIT_MISALIGNED);
  end

  // Beat datapath
  logic [31:0] beat_addr;
  logic [7:0]  beat_byte;
  logic        last_beat;
  logic [31:0] asm_next;
  logic [31:0] ext_data;

  always_comb begin
    beat_addr = addr_q + 32'(k_q);
    beat_byte = wdata_q[{k_q, 3'b000} +: 8];
    last_beat = (3'(k_q) == beats_q - 3'd1);
    // Split beats fill one byte lane each; an aligned beat takes the whole
    // (already right-aligned) memory word.
    asm_next  = asm_q;
    if (split_q) asm_next[{k_q, 3'b000} +: 8] = dm_dout[7:0];
    else         asm_next = dm_dout;
  end

  lsu_load_ext u_ext (
    .funct3 (f3_q),
    .word   (asm_next),
    .data   (ext_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and outputs
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    dm_rd_ctrl = DM_RD_NONE;
    dm_wr_ctrl = DM_WR_NONE;
    dm_addr    = '0;
    dm_din     = '0;
    case (state_q)
      ST_IDLE: begin
        // Held low while reset is asserted even though the state is IDLE
        req_ready = rst_n;
        if (req_valid && rst_n) state_d = req_fault ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        dm_addr = beat_addr;
        if (we_q) begin
          if (split_q) begin
            dm_wr_ctrl = DM_WR_B;
            dm_din     = {4{beat_byte}};
          end else begin
            case (f3_q[1:0])
              2'b00: begin
                dm_wr_ctrl = DM_WR_B;
                dm_din     = {4{wdata_q[7:0]}};
              end
              2'b01: begin
                dm_wr_ctrl = DM_WR_H;
                dm_din     = {2{wdata_q[15:0]}};
              end
              default: begin
                dm_wr_ctrl = DM_WR_W;
                dm_din     = wdata_q;
              end
            endcase
          end
        end else if (split_q) begin
          dm_rd_ctrl = DM_RD_LBU;
        end else begin
          case (f3_q)
            F3_B:    dm_rd_ctrl = DM_RD_LB;
            F3_H:    dm_rd_ctrl = DM_RD_LH;
            F3_W:    dm_rd_ctrl = DM_RD_LW;
            F3_BU:   dm_rd_ctrl = DM_RD_LBU;
            F3_HU:   dm_rd_ctrl = DM_RD_LHU;
            default: dm_rd_ctrl = DM_RD_NONE;
          endcase
        end
        if (last_beat) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, beat counter, assembly buffer and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      beats_q <= 3'd1;
      k_q     <= '0;
      split_q <= 1'b0;
      asm_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            beats_q <= req_misal ? req_size : 3'd1;
            split_q <= req_misal;
            k_q     <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
            err_q   <= req_fault;
          end
        end
        ST_ACCESS: begin
          k_q <= k_q + 2'd1;
          if (!we_q) asm_q <= asm_next;
          if (last_beat) begin
            rdata_q <= we_q ? '0 : ext_data;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized requests
// compared against a byte-level reference memory and access model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [2:0]  dm_rd_ctrl;
  logic [1:0]  dm_wr_ctrl;
  logic [31:0] dm_addr, dm_din, dm_dout;

  // Second instance with splitting disabled
  logic        n_req_valid, n_req_ready, n_req_we;
  logic [2:0]  n_req_funct3;
  logic [31:0] n_req_addr, n_req_wdata;
  logic        n_resp_valid, n_resp_ready, n_resp_err;
  logic [31:0] n_resp_rdata;
  logic [2:0]  n_dm_rd_ctrl;
  logic [1:0]  n_dm_wr_ctrl;
  logic [31:0] n_dm_addr, n_dm_din;
  logic [31:0] n_dm_dout = 32'h0;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_rdata;

  logic [7:0] mem     [0:16383] = '{default: 8'h00};
  logic [7:0] ref_mem [0:16383] = '{default: 8'h00};

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_ADDR_BITS(14), .SPLIT_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
  );

  lsu_ctrl #(.MEM_ADDR_BITS(14), .SPLIT_MISALIGNED(1'b0)) u_ns (
    .clk(clk), .rst_n(rst_n),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we),
    .req_funct3(n_req_funct3), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
    .resp_valid(n_resp_valid), .resp_ready(n_resp_ready),
    .resp_rdata(n_resp_rdata), .resp_err(n_resp_err),
    .dm_rd_ctrl(n_dm_rd_ctrl), .dm_wr_ctrl(n_dm_wr_ctrl),
    .dm_addr(n_dm_addr), .dm_din(n_dm_din), .dm_dout(n_dm_dout)
  );

  // Data memory: synchronous write, combinational right-aligned read
  logic [13:0] ma;
  assign ma = dm_addr[13:0];

  always @(posedge clk) begin
    case (dm_wr_ctrl)
      2'b01: mem[ma] <= dm_din[7:0];
      2'b10: begin
        mem[ma] <= dm_din[7:0]; mem[ma + 14'd1] <= dm_din[15:8];
      end
      2'b11: begin
        mem[ma]         <= dm_din[7:0];   mem[ma + 14'd1] <= dm_din[15:8];
        mem[ma + 14'd2] <= dm_din[23:16]; mem[ma + 14'd3] <= dm_din[31:24];
      end
      default: ;
    endcase
  end

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[ma]; b1 = mem[ma + 14'd1]; b2 = mem[ma + 14'd2]; b3 = mem[ma + 14'd3];
    dm_dout = 32'h0;
    case (dm_rd_ctrl)
      3'b001:  dm_dout = {{24{b0[7]}}, b0};
      3'b010:  dm_dout = {24'h0, b0};
      3'b011:  dm_dout = {{16{b1[7]}}, b1, b0};
      3'b100:  dm_dout = {16'h0, b1, b0};
      3'b101:  dm_dout = {b3, b2, b1, b0};
      default: dm_dout = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: outcome of one request from the architectural rules
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       output logic err, output logic [31:0] rdata,
                       output int beats, output int size, output logic misal);
    logic illegal, oor;
    longint unsigned val, lim;
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    oor     = (longint'(addr) + longint'(size) - 1) >= 64'd16384;
    misal   = (addr % size) != 0;
    err     = illegal || oor;
    beats   = err ? 0 : (misal ? size : 1);
    rdata   = 32'h0;
    if (!err && !we) begin
      val = 0;
      for (int i = 0; i < size; i++)
        val += longint'(ref_mem[(addr + i) % 16384]) << (8 * i);
      lim = 64'd1 << (8 * size);
      if (!f3[2] && val >= lim / 2) val = val + 64'hFFFF_FFFF_0000_0000 - (lim - 64'h1_0000_0000);
      rdata = val[31:0];
    end
  endtask

  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold);
    logic        e_err, e_misal;
    logic [31:0] e_rdata, r0, ea, ed;
    int          e_beats, e_size, lat, nb;
    logic        e0;
    logic [2:0]  tr_rd [8];
    logic [1:0]  tr_wr [8];
    logic [31:0] tr_addr [8];
    logic [31:0] tr_din [8];
    logic [2:0]  erd;
    logic [1:0]  ewr;
    logic [7:0]  bk;
    model(we, f3, addr, e_err, e_rdata, e_beats, e_size, e_misal);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; nb = 0;
    while (!resp_valid && lat < 20) begin
      if (nb < 8) begin
        tr_rd[nb] = dm_rd_ctrl; tr_wr[nb] = dm_wr_ctrl;
        tr_addr[nb] = dm_addr;  tr_din[nb] = dm_din;
      end
      nb++;
      @(posedge clk); #1;
      lat++;
    end
    chk("resp_arrives", 32'(resp_valid), 32'd1);
    chk("latency", 32'(lat), 32'(1 + e_beats));
    chk("beat_count", 32'(nb), 32'(e_beats));
    for (int k = 0; k < e_beats && k < nb && k < 8; k++) begin
      ea = addr + 32'(k);
      bk = wdata[8*k +: 8];
      if (e_misal) begin
        erd = 3'd2; ewr = 2'd1; ed = 32'(bk) * 32'h01010101;
      end else begin
        case (f3)
          3'd0: erd = 3'd1; 3'd4: erd = 3'd2; 3'd1: erd = 3'd3;
          3'd5: erd = 3'd4; default: erd = 3'd5;
        endcase
        ewr = (e_size == 1) ? 2'd1 : (e_size == 2) ? 2'd2 : 2'd3;
        ed  = (e_size == 1) ? 32'(wdata[7:0]) * 32'h01010101 :
              (e_size == 2) ? 32'(wdata[15:0]) * 32'h00010001 : wdata;
      end
      chk("beat_addr", tr_addr[k], ea);
      if (we) begin
        chk("beat_wr", 32'(tr_wr[k]), 32'(ewr));
        chk("beat_rd_idle", 32'(tr_rd[k]), 32'd0);
        chk("beat_din", tr_din[k], ed);
      end else begin
        chk("beat_rd", 32'(tr_rd[k]), 32'(erd));
        chk("beat_wr_idle", 32'(tr_wr[k]), 32'd0);
      end
    end
    chk("resp_err", 32'(resp_err), 32'(e_err));
    chk("resp_rdata", resp_rdata, e_rdata);
    chk("dm_idle_in_resp", {27'h0, dm_rd_ctrl, dm_wr_ctrl}, 32'h0);
    r0 = resp_rdata; e0 = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, r0);
      chk("hold_err", 32'(resp_err), 32'(e0));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
    if (we && !e_err) begin
      for (int i = 0; i < e_size; i++) ref_mem[(addr + i) % 16384] = wdata[8*i +: 8];
      for (int i = 0; i < e_size; i++)
        chk("mem_byte", 32'(mem[(addr + i) % 16384]), 32'(ref_mem[(addr + i) % 16384]));
    end
    last_rdata = r0;
  endtask

  initial begin
    logic [31:0] a, w;
    int sel;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    n_req_valid = 1'b0; n_req_we = 1'b0; n_req_funct3 = 3'd0;
    n_req_addr = 32'h0; n_req_wdata = 32'h0; n_resp_ready = 1'b0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_dm", {27'h0, dm_rd_ctrl, dm_wr_ctrl}, 32'h0);
    chk("rst_dm_addr_din", dm_addr | dm_din, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Sign/zero extension of aligned loads
    run(1'b1, 3'd2, 32'h100, 32'h87654321, 0);
    run(1'b0, 3'd2, 32'h100, 32'h0, 0); chk("lw_100", last_rdata, 32'h87654321);
    run(1'b0, 3'd1, 32'h102, 32'h0, 0); chk("lh_102", last_rdata, 32'hFFFF8765);
    run(1'b0, 3'd5, 32'h102, 32'h0, 0); chk("lhu_102", last_rdata, 32'h00008765);
    run(1'b0, 3'd0, 32'h103, 32'h0, 0); chk("lb_103", last_rdata, 32'hFFFFFF87);

    // Misaligned word load across a word boundary
    run(1'b1, 3'd2, 32'h100, 32'h44332211, 0);
    run(1'b1, 3'd2, 32'h104, 32'h88776655, 0);
    run(1'b0, 3'd2, 32'h101, 32'h0, 0); chk("lw_101", last_rdata, 32'h55443322);

    // Split halfword store then read back
    run(1'b1, 3'd1, 32'h103, 32'h00001234, 0);
    run(1'b0, 3'd5, 32'h103, 32'h0, 0); chk("lhu_103", last_rdata, 32'h00001234);

    // Faults
    run(1'b0, 3'd2, 32'h3FFE, 32'h0, 0);
    run(1'b0, 3'd3, 32'h100, 32'h0, 0);
    run(1'b1, 3'd4, 32'h100, 32'h0, 0);
    run(1'b0, 3'd0, 32'h3FFF, 32'h0, 0);

    // Response back-pressure
    run(1'b0, 3'd2, 32'h100, 32'h0, 5);

    // Misaligned access rejected when splitting is disabled
    @(negedge clk);
    n_req_valid = 1'b1; n_req_we = 1'b0; n_req_funct3 = 3'd2; n_req_addr = 32'h102;
    @(posedge clk); #1;
    n_req_valid = 1'b0;
    chk("ns_resp_valid", 32'(n_resp_valid), 32'd1);
    chk("ns_resp_err", 32'(n_resp_err), 32'd1);
    chk("ns_resp_rdata", n_resp_rdata, 32'h0);
    chk("ns_dm_idle", {27'h0, n_dm_rd_ctrl, n_dm_wr_ctrl}, 32'h0);
    n_resp_ready = 1'b1;
    @(posedge clk); #1;
    n_resp_ready = 1'b0;
    chk("ns_req_ready", 32'(n_req_ready), 32'd1);

    // Reset during beat 2 of a split word store
    run(1'b1, 3'd2, 32'h200, 32'h0, 0);
    run(1'b1, 3'd2, 32'h204, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h201; req_wdata = 32'hDDCCBBAA;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("beat2_wr", 32'(dm_wr_ctrl), 32'd1);
    chk("beat2_addr", dm_addr, 32'h203);
    rst_n = 1'b0;
    #1;
    chk("abort_wr", 32'(dm_wr_ctrl), 32'd0);
    chk("abort_addr", dm_addr, 32'h0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    ref_mem[16'h201] = 8'hAA; ref_mem[16'h202] = 8'hBB;
    chk("abort_byte0", 32'(mem[16'h201]), 32'hAA);
    chk("abort_byte1", 32'(mem[16'h202]), 32'hBB);
    chk("abort_byte2", 32'(mem[16'h203]), 32'h00);
    chk("abort_byte3", 32'(mem[16'h204]), 32'h00);

    // Randomized requests against the reference model
    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, 16383));
      else if (sel == 7) a = 32'(16376 + $urandom_range(0, 7));
      else if (sel == 8) a = $urandom;
      else               a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      w = $urandom;
      run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, w, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
